gamma_lut_ctrl: RTL

//  Double-buffered gamma LUT controller for one 8-bit colour channel. It owns two
//  256x8 table banks and serves the active bank to the pixel stream, while a

---
 rtl/gamma_lut_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gamma_lut_ctrl.sv
// Double-buffered gamma LUT for one 8-bit colour channel.
// Pixels are served from the active bank with a fixed 2-cycle latency. A config
// master fills the shadow bank; a commit arms a swap that happens only on the
// next vsync rising edge, so a frame never mixes two tables.
module gamma_lut_ctrl #(
    parameter bit LAT_BYPASS_EQ = 1'b1  // 1: bypass path matches the 2-cycle LUT latency
) (
    input  logic       clk,
    input  logic       rst_n,
    // Pixel stream
    input  logic       i_vsync,
    input  logic       i_de,
    input  logic [7:0] i_data,
    output logic       o_vsync,
    output logic       o_de,
    output logic [7:0] o_data,
    // Configuration
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic       cfg_commit,
    input  logic       cfg_bypass,
    // Status
    output logic       o_active_bank,
    output logic       o_swap_pending,
    output logic       o_lut_valid
);

    typedef enum logic [0:0] {
        StIdle,
        StPending
    } state_e;

    // Table storage, deliberately not reset.
    logic [7:0] bank0_mem [256];
    logic [7:0] bank1_mem [256];

    // Control state
    state_e state_q, state_d;
    logic   active_bank_q, active_bank_d;
    logic   lut_valid_q, lut_valid_d;
    logic   swap_pending_q, swap_pending_d;
    logic   cfg_ready_q, cfg_ready_d;

    // Stage 1 of the pixel pipe
    logic [7:0] s1_data_q, s1_data_d;
    logic       s1_de_q, s1_de_d;
    logic       s1_vsync_q, s1_vsync_d;
    logic       s1_bypass_q, s1_bypass_d;
    logic       s1_bank_q, s1_bank_d;
    logic       s1_lut_en_q, s1_lut_en_d;
    logic       vsync_prev_q, vsync_prev_d;

    // Stage 2 of the pixel pipe
    logic [7:0] s2_data_q, s2_data_d;
    logic       s2_de_q, s2_de_d;
    logic       s2_vsync_q, s2_vsync_d;

    logic       vsync_rise;
    logic       wr_en;
    logic       wr_bank;
    logic [7:0] lut_rd;

    // Edge taken from the registered vsync so it lines up with stage 1.
    assign vsync_rise = s1_vsync_q & ~vsync_prev_q;

    // Writes land in the shadow bank; cfg_ready_q is high only in idle.
    assign wr_en   = cfg_valid & cfg_ready_q;
    assign wr_bank = ~active_bank_q;

    // Shadow-bank write port
    always_ff @(posedge clk) begin
        if (wr_en && !wr_bank) begin
            bank0_mem[cfg_addr] <= cfg_data;
        end
        if (wr_en && wr_bank) begin
            bank1_mem[cfg_addr] <= cfg_data;
        end
    end

    // Table lookup using the bank latched with the pixel at stage 1
    always_comb begin
        lut_rd = s1_bank_q ? bank1_mem[s1_data_q] : bank0_mem[s1_data_q];
    end

    // Commit / swap control next state
    always_comb begin
        state_d       = state_q;
        active_bank_d = active_bank_q;
        lut_valid_d   = lut_valid_q;
        unique case (state_q)
            StIdle: begin
                // A coincident vsync edge is ignored here; the swap waits for the next one.
                if (cfg_commit) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (vsync_rise) begin
                    state_d       = StIdle;
                    active_bank_d = ~active_bank_q;
                    lut_valid_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        swap_pending_d = (state_d == StPending);
        cfg_ready_d    = (state_d == StIdle);
    end

    // Commit / swap control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            active_bank_q  <= 1'b0;
            lut_valid_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            cfg_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            active_bank_q  <= active_bank_d;
            lut_valid_q    <= lut_valid_d;
            swap_pending_q <= swap_pending_d;
            cfg_ready_q    <= cfg_ready_d;
        end
    end

    // Pixel pipe next state
    always_comb begin
        s1_data_d    = i_data;
        s1_de_d      = i_de;
        s1_vsync_d   = i_vsync;
        s1_bypass_d  = cfg_bypass;
        s1_bank_d    = active_bank_q;
        s1_lut_en_d  = lut_valid_q;
        vsync_prev_d = s1_vsync_q;
        // Identity output until a table has been committed or when bypassed.
        s2_data_d    = (s1_lut_en_q && !s1_bypass_q) ? lut_rd : s1_data_q;
        s2_de_d      = s1_de_q;
        s2_vsync_d   = s1_vsync_q;
    end

    // Pixel pipe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q    <= 8'h00;
            s1_de_q      <= 1'b0;
            s1_vsync_q   <= 1'b0;
            s1_bypass_q  <= 1'b0;
            s1_bank_q    <= 1'b0;
            s1_lut_en_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
            s2_data_q    <= 8'h00;
            s2_de_q      <= 1'b0;
            s2_vsync_q   <= 1'b0;
        end else begin
            s1_data_q    <= s1_data_d;
            s1_de_q      <= s1_de_d;
            s1_vsync_q   <= s1_vsync_d;
            s1_bypass_q  <= s1_bypass_d;
            s1_bank_q    <= s1_bank_d;
            s1_lut_en_q  <= s1_lut_en_d;
            vsync_prev_q <= vsync_prev_d;
            s2_data_q    <= s2_data_d;
            s2_de_q      <= s2_de_d;
            s2_vsync_q   <= s2_vsync_d;
        end
    end

    // Without latency matching, a bypassed pixel leaves straight from stage 1.
    assign o_data = (!LAT_BYPASS_EQ && s1_bypass_q) ? s1_data_q : s2_data_q;

    assign o_de           = s2_de_q;
    assign o_vsync        = s2_vsync_q;
    assign cfg_ready      = cfg_ready_q;
    assign o_active_bank  = active_bank_q;
    assign o_swap_pending = swap_pending_q;
    assign o_lut_valid    = lut_valid_q;

endmodule
